konami_082_timing: RTL and testbench
====================================

# konami_082_timing

Video timing generator feeding the konami_504 timing/watchdog stage. Runs the horizontal and vertical raster counters from the pixel clock enable and produces the 1H..256H and 1V..256V count buses, nHSYNC, nHBLANK, nVSYNC, nVBLANK, and a one-pixel VBLANK-start pulse for the CPU IRQ logic. Its 4H, 8H, n256H and nVBLANK outputs drive the 504's p12, p13, p08 and p09 pins directly.

## Interface
- H_START, 128: first horizontal count value after wrap.
- H_END, 511: last horizontal count value. A line is 384 pixels.
- HSYNC_FIRST, 176: first H count with nHSYNC low.
- HSYNC_LAST, 207: last H count with nHSYNC low.
- HBLANK_LAST, 255: nHBLANK is low for H_START..HBLANK_LAST.
- V_START, 248: first vertical count value after wrap.
- V_END, 511: last vertical count value. A frame is 264 lines.
- VSYNC_LAST, 255: nVSYNC is low for V_START..VSYNC_LAST.
- VBLANK_FIRST, 496: nVBLANK is low for V >= VBLANK_FIRST.
- VBLANK_LAST, 271: nVBLANK is also low for V <= VBLANK_LAST.

Ports:
- clk  in  1  system clock. All state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- ce_i  in  1  pixel clock enable. One pixel per clk with ce_i high.
- flip_i  in  1  screen flip request.
- h_o  out  9  raw H count; bit 0 = 1H, bit 8 = 256H.
- n256h_o  out  1  ~h_o[8].
- v_o  out  9  raw V count; bit 0 = 1V.
- hf_o  out  8  h_o[7:0] XOR {8{flip_q}}.
- vf_o  out  8  v_o[7:0] XOR {8{flip_q}}.
- nhsync_o  out  1  active-low horizontal sync.
- nhblank_o  out  1  active-low horizontal blank.
- nvsync_o  out  1  active-low vertical sync.
- nvblank_o  out  1  active-low vertical blank.
- vblank_start_o  out  1  one-ce-period pulse when blanking begins.

## Operation
- **H counter:** 9 bits. On each ce_i, it increments; when it is at H_END it loads H_START.
- **V counter:** 9 bits. It advances only on the ce_i where H wraps. When it is at V_END it loads V_START.
- **Frame boundary:** the ce_i on which both counters wrap, giving H=H_START and V=V_START.
- **flip_q:** captures flip_i only at the frame boundary. A flip_i change mid-frame has no effect until the next frame.
- **Decodes:** all outputs are registered, and are a pure function of the current counter state and flip_q.
  - nhsync_o = 0 iff HSYNC_FIRST <= H <= HSYNC_LAST.
  - nhblank_o = 0 iff H <= HBLANK_LAST.
  - nvsync_o = 0 iff V <= VSYNC_LAST.
  - nvblank_o = 0 iff V >= VBLANK_FIRST or V <= VBLANK_LAST. Visible lines are 272..495, 224 lines.
- **vblank_start_o:** high for exactly the ce_i period in which H=H_START and V=VBLANK_FIRST. Low otherwise.
- **Width rule:** no count value outside H_START..H_END or V_START..V_END is ever output.

## Timing
- **Reset:**
  - Counters: H=H_END (511), V=V_END (511), flip_q=0.
  - Output values: h_o=511, v_o=511, n256h_o=0, hf_o=vf_o=8'hFF, nhsync_o=1, nhblank_o=1, nvsync_o=1, nvblank_o=0, vblank_start_o=0.
- **Leaving reset:** the first ce_i after reset is a frame boundary, giving H=128, V=248, nvsync_o=0, nhblank_o=0. flip_i is sampled at that point.
- **Output latency:** outputs change on the same clk edge that updates the counters. There is zero latency between h_o/v_o and the decodes.
- **ce_i low:** every register holds. vblank_start_o holds its value, so the pulse lasts one ce period, not one clk.
- **Reset mid-frame:** takes priority over ce_i and returns all state to the reset values on that edge.

## Structure
- **Package konami_video_pkg:**
  - All timing defaults as localparams: H_START, H_END, HSYNC_FIRST, HSYNC_LAST, HBLANK_LAST, V_START, V_END, VSYNC_LAST, VBLANK_FIRST, VBLANK_LAST.
  - Derived constants: LINE_PIXELS = 384, FRAME_LINES = 264.
  - These are shared with the later sprite/tilemap blocks.
- **Sub-module wrap_counter:**
  - Parameters: WIDTH, START, END.
  - Ports: clk, reset, en, count, wrap.
  - Instantiated twice: H uses en=ce_i. V uses en=ce_i & H-wrap.

## Test plan
- **Reset release:** assert reset for 3 clk, then ce_i every clk. Required: reset values as listed. After the first ce, h_o=128, v_o=248, nvsync_o=0.
- **Line timing:** count ce over one line. Required:
  - H runs 128..511 and wraps to 128 after exactly 384 ce.
  - nhsync_o is low for exactly 32 ce, starting at H=176.
  - nhblank_o is low for exactly 128 ce.
- **Frame timing:** run a full frame. Required:
  - V advances once per 384 ce; 264 lines per frame (101376 ce).
  - nvsync_o is low for 8 lines.
  - nvblank_o is low for 40 lines.
  - vblank_start_o pulses exactly once, at V=496/H=128.
- **ce_i gating:** ce_i high every 4th clk. Required: counters and vblank_start_o hold between enables. The pulse width equals 4 clk.
- **Flip latching:**
  - Toggle flip_i at V=300. Required: hf_o/vf_o stay unflipped until the next frame boundary.
  - At the boundary, hf_o = ~h_o[7:0] (H=128 gives hf_o=8'h7F).
- **Reset mid-frame:** assert reset at H=300/V=400 with ce_i high. Required: the next edge shows the reset values, with no partial increment.

Source files
------------

// File: rtl/konami_video_pkg.sv
// Shared raster timing constants and decode types for the Konami video blocks.
// The sprite and tilemap stages import the same geometry.
package konami_video_pkg;

   localparam logic [8:0] H_START      = 9'd128;
   localparam logic [8:0] H_END        = 9'd511;
   localparam logic [8:0] HSYNC_FIRST  = 9'd176;
   localparam logic [8:0] HSYNC_LAST   = 9'd207;
   localparam logic [8:0] HBLANK_LAST  = 9'd255;
   localparam logic [8:0] V_START      = 9'd248;
   localparam logic [8:0] V_END        = 9'd511;
   localparam logic [8:0] VSYNC_LAST   = 9'd255;
   localparam logic [8:0] VBLANK_FIRST = 9'd496;
   localparam logic [8:0] VBLANK_LAST  = 9'd271;

   localparam int unsigned LINE_PIXELS = 32'(H_END - H_START) + 32'd1;
   localparam int unsigned FRAME_LINES = 32'(V_END - V_START) + 32'd1;

   typedef struct packed {
      logic       n256h;
      logic [7:0] hf;
      logic [7:0] vf;
      logic       nhsync;
      logic       nhblank;
      logic       nvsync;
      logic       nvblank;
      logic       vblank_start;
   } timing_out_t;

   function automatic logic in_range(input logic [8:0] x,
                                     input logic [8:0] lo,
                                     input logic [8:0] hi);
      return (x >= lo) && (x <= hi);
   endfunction

endpackage

// File: rtl/konami_082_timing_wrap_counter.sv
// Enabled up-counter running START..END, reloading START after END.
// Resets to END so the first enable behaves like a wrap.
module wrap_counter #(
   parameter int unsigned      WIDTH = 9,
   parameter logic [WIDTH-1:0] START = '0,
   parameter logic [WIDTH-1:0] END   = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   assign wrap = en && (count == END);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= END;
      end else if (en) begin
         count <= wrap ? START : count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/konami_082_timing.sv
// Raster timing generator: H/V counters, sync/blank decodes, flip latch and
// the VBLANK-start pulse that feeds the CPU interrupt logic.
module konami_082_timing #(
   parameter logic [8:0] H_START      = konami_video_pkg::H_START,
   parameter logic [8:0] H_END        = konami_video_pkg::H_END,
   parameter logic [8:0] HSYNC_FIRST  = konami_video_pkg::HSYNC_FIRST,
   parameter logic [8:0] HSYNC_LAST   = konami_video_pkg::HSYNC_LAST,
   parameter logic [8:0] HBLANK_LAST  = konami_video_pkg::HBLANK_LAST,
   parameter logic [8:0] V_START      = konami_video_pkg::V_START,
   parameter logic [8:0] V_END        = konami_video_pkg::V_END,
   parameter logic [8:0] VSYNC_LAST   = konami_video_pkg::VSYNC_LAST,
   parameter logic [8:0] VBLANK_FIRST = konami_video_pkg::VBLANK_FIRST,
   parameter logic [8:0] VBLANK_LAST  = konami_video_pkg::VBLANK_LAST
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce_i,
   input  logic       flip_i,
   output logic [8:0] h_o,
   output logic       n256h_o,
   output logic [8:0] v_o,
   output logic [7:0] hf_o,
   output logic [7:0] vf_o,
   output logic       nhsync_o,
   output logic       nhblank_o,
   output logic       nvsync_o,
   output logic       nvblank_o,
   output logic       vblank_start_o
);

   import konami_video_pkg::timing_out_t;
   import konami_video_pkg::in_range;

   logic [8:0]  h_cnt;
   logic [8:0]  v_cnt;
   logic        h_wrap;
   logic        v_wrap;
   logic        v_en;
   logic        flip_q;
   logic        flip_next;
   logic [8:0]  h_next;
   logic [8:0]  v_next;
   timing_out_t dec_next;
   timing_out_t dec_q;

   function automatic timing_out_t decode(input logic [8:0] h,
                                          input logic [8:0] v,
                                          input logic       f);
      timing_out_t d;
      d.n256h        = ~h[8];
      d.hf           = h[7:0] ^ {8{f}};
      d.vf           = v[7:0] ^ {8{f}};
      d.nhsync       = ~in_range(h, HSYNC_FIRST, HSYNC_LAST);
      d.nhblank      = ~(h <= HBLANK_LAST);
      d.nvsync       = ~(v <= VSYNC_LAST);
      d.nvblank      = ~((v >= VBLANK_FIRST) || (v <= VBLANK_LAST));
      d.vblank_start = (h == H_START) && (v == VBLANK_FIRST);
      return d;
   endfunction

   assign v_en = ce_i & h_wrap;

   wrap_counter #(.WIDTH(9), .START(H_START), .END(H_END)) u_hcnt (
      .clk   (clk),
      .reset (reset),
      .en    (ce_i),
      .count (h_cnt),
      .wrap  (h_wrap)
   );

   wrap_counter #(.WIDTH(9), .START(V_START), .END(V_END)) u_vcnt (
      .clk   (clk),
      .reset (reset),
      .en    (v_en),
      .count (v_cnt),
      .wrap  (v_wrap)
   );

   // Decodes are computed from the counters' next values so the registered
   // outputs line up with h_o/v_o on the same edge.
   always_comb begin
      h_next    = h_wrap ? H_START : h_cnt + 9'd1;
      v_next    = v_cnt;
      if (v_en) begin
         v_next = v_wrap ? V_START : v_cnt + 9'd1;
      end
      flip_next = v_wrap ? flip_i : flip_q;
      dec_next  = decode(h_next, v_next, flip_next);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flip_q <= 1'b0;
         dec_q  <= decode(H_END, V_END, 1'b0);
      end else if (ce_i) begin
         flip_q <= flip_next;
         dec_q  <= dec_next;
      end
   end

   assign h_o            = h_cnt;
   assign v_o            = v_cnt;
   assign n256h_o        = dec_q.n256h;
   assign hf_o           = dec_q.hf;
   assign vf_o           = dec_q.vf;
   assign nhsync_o       = dec_q.nhsync;
   assign nhblank_o      = dec_q.nhblank;
   assign nvsync_o       = dec_q.nvsync;
   assign nvblank_o      = dec_q.nvblank;
   assign vblank_start_o = dec_q.vblank_start;

endmodule

// File: tb/tb_konami_082_timing.sv
// Scoreboard bench for konami_082_timing: a full-geometry instance for line
// timing and a short-line instance so whole frames fit in a short run.
module tb_konami_082_timing;

   logic clk    = 1'b0;
   logic reset  = 1'b1;
   logic ce_i   = 1'b0;
   logic flip_i = 1'b0;

   always #5 clk = ~clk;

   logic [8:0] h0, v0, h1, v1;
   logic [7:0] hf0, vf0, hf1, vf1;
   logic       n256h0, nhs0, nhb0, nvs0, nvb0, vbs0;
   logic       n256h1, nhs1, nhb1, nvs1, nvb1, vbs1;

   konami_082_timing u_dut0 (
      .clk(clk), .reset(reset), .ce_i(ce_i), .flip_i(flip_i),
      .h_o(h0), .n256h_o(n256h0), .v_o(v0), .hf_o(hf0), .vf_o(vf0),
      .nhsync_o(nhs0), .nhblank_o(nhb0), .nvsync_o(nvs0), .nvblank_o(nvb0),
      .vblank_start_o(vbs0)
   );

   // 16-pixel lines (496..511); vertical geometry left at the real values.
   konami_082_timing #(
      .H_START(9'd496), .H_END(9'd511), .HSYNC_FIRST(9'd500),
      .HSYNC_LAST(9'd503), .HBLANK_LAST(9'd499)
   ) u_dut1 (
      .clk(clk), .reset(reset), .ce_i(ce_i), .flip_i(flip_i),
      .h_o(h1), .n256h_o(n256h1), .v_o(v1), .hf_o(hf1), .vf_o(vf1),
      .nhsync_o(nhs1), .nhblank_o(nhb1), .nvsync_o(nvs1), .nvblank_o(nvb1),
      .vblank_start_o(vbs1)
   );

   typedef struct packed {
      logic [8:0] h;
      logic [8:0] v;
      logic       n256h;
      logic [7:0] hf;
      logic [7:0] vf;
      logic       nhs;
      logic       nhb;
      logic       nvs;
      logic       nvb;
      logic       vbs;
   } obs_t;

   typedef struct {
      int h;
      int v;
      bit f;
   } mst_t;

   typedef struct {
      int hs;
      int he;
      int hsf;
      int hsl;
      int hbl;
   } hcfg_t;

   obs_t obs0, obs1;
   assign obs0 = {h0, v0, n256h0, hf0, vf0, nhs0, nhb0, nvs0, nvb0, vbs0};
   assign obs1 = {h1, v1, n256h1, hf1, vf1, nhs1, nhb1, nvs1, nvb1, vbs1};

   hcfg_t cfg0 = '{hs: 128, he: 511, hsf: 176, hsl: 207, hbl: 255};
   hcfg_t cfg1 = '{hs: 496, he: 511, hsf: 500, hsl: 503, hbl: 499};
   mst_t  m0, m1;
   obs_t  q0[$];
   obs_t  q1[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   function automatic mst_t step(mst_t s, bit r, bit c, bit fl, hcfg_t g);
      mst_t n = s;
      if (r) begin
         n.h = 511; n.v = 511; n.f = 1'b0;
      end else if (c) begin
         if (s.h == g.he) begin
            n.h = g.hs;
            if (s.v == 511) begin
               n.v = 248;
               n.f = fl;
            end else begin
               n.v = s.v + 1;
            end
         end else begin
            n.h = s.h + 1;
         end
      end
      return n;
   endfunction

   function automatic obs_t exp_of(mst_t s, hcfg_t g);
      obs_t o;
      o.h     = 9'(s.h);
      o.v     = 9'(s.v);
      o.n256h = ~o.h[8];
      o.hf    = o.h[7:0] ^ {8{s.f}};
      o.vf    = o.v[7:0] ^ {8{s.f}};
      o.nhs   = !(s.h >= g.hsf && s.h <= g.hsl);
      o.nhb   = !(s.h <= g.hbl);
      o.nvs   = !(s.v <= 255);
      o.nvb   = !(s.v >= 496 || s.v <= 271);
      o.vbs   = (s.h == g.hs) && (s.v == 496);
      return o;
   endfunction

   task automatic check_int(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic check_obs(input string name, input obs_t got, input obs_t want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s @%0t: got h=%0d v=%0d n256h=%b hf=%h vf=%h hs=%b hb=%b vs=%b vb=%b vbs=%b, expected h=%0d v=%0d n256h=%b hf=%h vf=%h hs=%b hb=%b vs=%b vb=%b vbs=%b",
                  name, $time, got.h, got.v, got.n256h, got.hf, got.vf, got.nhs, got.nhb,
                  got.nvs, got.nvb, got.vbs, want.h, want.v, want.n256h, want.hf, want.vf,
                  want.nhs, want.nhb, want.nvs, want.nvb, want.vbs);
      end
   endtask

   // Monitor: every clk presents one registered state per instance.
   always @(negedge clk) begin
      obs_t e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         check_obs("dut0_state", obs0, e);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         check_obs("dut1_state", obs1, e);
      end
   end

   task automatic tick(input bit r, input bit c);
      reset = r;
      ce_i  = c;
      @(posedge clk);
      m0 = step(m0, r, c, flip_i, cfg0);
      m1 = step(m1, r, c, flip_i, cfg1);
      q0.push_back(exp_of(m0, cfg0));
      q1.push_back(exp_of(m1, cfg1));
      #1;
   endtask

   task automatic run_until_v(input int target, input int budget);
      for (int i = 0; i < budget && int'(v1) != target; i++) tick(1'b0, 1'b1);
      if (int'(v1) != target) check_int("wait_v_timeout", int'(v1), target);
   endtask

   initial begin
      int hs_low = 0, hb_low = 0, hs_first = -1, h_back = -1;
      int vs_low = 0, vb_low = 0, vbs_cnt = 0, vbs_h = -1, vbs_v = -1;
      int pw = 0;

      m0 = '{h: 0, v: 0, f: 1'b0};
      m1 = '{h: 0, v: 0, f: 1'b0};

      for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);

      // One full short-line frame plus the following boundary.
      for (int n = 1; n <= 4225; n++) begin
         tick(1'b0, 1'b1);
         if (n == 1) begin
            check_int("first_h", int'(h0), 128);
            check_int("first_v", int'(v0), 248);
            check_int("first_nvsync", int'(nvs0), 0);
            check_int("first_nhblank", int'(nhb0), 0);
         end
         if (n <= 384) begin
            if (!nhs0) begin
               hs_low++;
               if (hs_first < 0) hs_first = int'(h0);
            end
            if (!nhb0) hb_low++;
         end
         if (n > 1 && h_back < 0 && h0 == 9'd128) h_back = n;
         if (n == 385) check_int("v_advance", int'(v0), 249);
         if (n <= 4224) begin
            if (!nvs1) vs_low++;
            if (!nvb1) vb_low++;
            if (vbs1) begin
               vbs_cnt++;
               vbs_h = int'(h1);
               vbs_v = int'(v1);
            end
         end
         if (n == 4224) check_int("hf_before_boundary", int'(hf1), 'hFF);
         if (n == 4225) begin
            check_int("hf_at_boundary", int'(hf1), 'h0F);
            check_int("vf_at_boundary", int'(vf1), 'h07);
            check_int("frame_wrap_h", int'(h1), 496);
            check_int("frame_wrap_v", int'(v1), 248);
         end
         if (v1 == 9'd300) flip_i = 1'b1;
      end
      check_int("hsync_low_ce", hs_low, 32);
      check_int("hsync_first_h", hs_first, 176);
      check_int("hblank_low_ce", hb_low, 128);
      check_int("line_wrap_ce", h_back, 385);
      check_int("vsync_low_ce", vs_low, 8 * 16);
      check_int("vblank_low_ce", vb_low, 40 * 16);
      check_int("vbstart_pulses", vbs_cnt, 1);
      check_int("vbstart_h", vbs_h, 496);
      check_int("vbstart_v", vbs_v, 496);

      // ce every 4th clk across the VBLANK start.
      run_until_v(490, 5000);
      for (int k = 0; k < 4000 && v1 != 9'd497; k++) begin
         tick(1'b0, (k % 4) == 0);
         if (vbs1) pw++;
      end
      check_int("gated_reach_v", int'(v1), 497);
      check_int("vbstart_width_clk", pw, 4);

      // Reset mid-frame with ce high.
      run_until_v(400, 6000);
      tick(1'b1, 1'b1);
      check_int("midreset_h0", int'(h0), 511);
      check_int("midreset_v0", int'(v0), 511);
      check_int("midreset_nvblank", int'(nvb0), 0);
      check_int("midreset_v1", int'(v1), 511);
      check_int("midreset_hf1", int'(hf1), 'hFF);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b1);
      check_int("post_reset_h0", int'(h0), 128);
      check_int("post_reset_v0", int'(v0), 248);
      tick(1'b0, 1'b0);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
